// File: rtl/xmpl_dsp_seq_pkg.sv
// Shared types for the xmpl DSP chain sequencer.
// State encoding and the mask scan helper used for stage ordering.
package xmpl_dsp_seq_pkg;

    localparam int MAX_STAGES = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE,
        S_ERR  = ST_ERR
    } seq_state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } next_bit_t;

    // Lowest set bit of mask at or above position from.
    function automatic next_bit_t next_set_bit(
        input logic [15:0] mask,
        input logic [4:0]  from
    );
        next_bit_t r;
        r = '0;
        for (int i = MAX_STAGES - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) begin
                r.valid = 1'b1;
                r.idx   = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/xmpl_dsp_seq_timer.sv
// Per-stage cycle counter with limit compare.
// A zero limit never expires.
module xmpl_dsp_seq_timer #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Fires on the cycle whose edge completes the limit-th stage cycle.
    assign expire_o = (limit_i != '0) && (cnt_q == limit_i - 1'b1);

endmodule

// File: rtl/xmpl_dsp_seq.sv
// Sequencer for the xmpl DSP chain: runs masked stages in index order,
// with per-stage timeout, single-shot/continuous frames and a frame counter.
module xmpl_dsp_seq
    import xmpl_dsp_seq_pkg::*;
#(
    parameter int N_STAGES  = 3,
    parameter int TIMEOUT_W = 16,
    parameter int FRAME_W   = 16,
    localparam int IDX_W    = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 en_xmpl_dsp_seq_i,
    input  logic                 mode_i,
    input  logic [N_STAGES-1:0]  stage_mask_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    input  logic [N_STAGES-1:0]  stage_status_i,
    output logic [N_STAGES-1:0]  stage_en_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [IDX_W-1:0]     err_stage_o,
    output logic [FRAME_W-1:0]   frame_cnt_o,
    output logic [1:0]           seq_state_o
);

    seq_state_t           state_q, state_d;
    logic [N_STAGES-1:0]  mask_q, mask_d;
    logic                 mode_q, mode_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic [IDX_W-1:0]     cur_q, cur_d;
    logic [IDX_W-1:0]     err_stage_q, err_stage_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 armed_q, armed_d;
    logic [N_STAGES-1:0]  stage_en_d;
    logic                 done_d;
    logic                 tmr_clr;
    logic                 tmr_en;
    logic                 expire;
    next_bit_t            nb;
    logic                 en;

    assign en = en_xmpl_dsp_seq_i;

    xmpl_dsp_seq_timer #(
        .W(TIMEOUT_W)
    ) u_timer (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .limit_i  (tmo_q),
        .expire_o (expire)
    );

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        mode_d      = mode_q;
        tmo_d       = tmo_q;
        cur_d       = cur_q;
        err_stage_d = err_stage_q;
        frame_d     = frame_q;
        armed_d     = armed_q;
        done_d      = 1'b0;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;
        nb          = '0;

        unique case (state_q)
            S_IDLE: begin
                if (en && armed_q) begin
                    mask_d      = stage_mask_i;
                    mode_d      = mode_i;
                    tmo_d       = timeout_i;
                    err_stage_d = '0;
                    tmr_clr     = 1'b1;
                    nb = next_set_bit(16'(stage_mask_i), 5'd0);
                    if (nb.valid) begin
                        cur_d   = nb.idx[IDX_W-1:0];
                        state_d = S_RUN;
                    end else begin
                        done_d  = 1'b1;
                        frame_d = frame_q + 1'b1;
                        state_d = S_DONE;
                    end
                    if (!mode_i) begin
                        armed_d = 1'b0;
                    end
                end
            end
            S_RUN: begin
                tmr_en = 1'b1;
                // Abort beats stage done, which beats timeout.
                if (!en) begin
                    state_d = S_IDLE;
                end else if (stage_status_i[cur_q]) begin
                    nb = next_set_bit(16'(mask_q), 5'(cur_q) + 5'd1);
                    if (nb.valid) begin
                        cur_d   = nb.idx[IDX_W-1:0];
                        tmr_clr = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        frame_d = frame_q + 1'b1;
                        state_d = S_DONE;
                    end
                end else if (expire) begin
                    err_stage_d = cur_q;
                    state_d     = S_ERR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                if (!en) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!en) begin
            armed_d = 1'b1;
        end

        for (int k = 0; k < N_STAGES; k++) begin
            stage_en_d[k] = (state_d == S_RUN) && (cur_d == IDX_W'(k));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            mode_q      <= 1'b0;
            tmo_q       <= '0;
            cur_q       <= '0;
            err_stage_q <= '0;
            frame_q     <= '0;
            armed_q     <= 1'b1;
            stage_en_o  <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            mode_q      <= mode_d;
            tmo_q       <= tmo_d;
            cur_q       <= cur_d;
            err_stage_q <= err_stage_d;
            frame_q     <= frame_d;
            armed_q     <= armed_d;
            stage_en_o  <= stage_en_d;
            busy_o      <= (state_d == S_RUN);
            done_o      <= done_d;
            err_o       <= (state_d == S_ERR);
        end
    end

    assign err_stage_o = err_stage_q;
    assign frame_cnt_o = frame_q;
    assign seq_state_o = state_q;

endmodule
